// File: rtl/norm_feeder.sv
// norm_feeder: pops psum rows from the ofifo, runs each through the normalizer's
// valid/div_complete handshake and writes the normalized row to the result SRAM.
module norm_feeder #(
  parameter int BW      = 8,
  parameter int BW_PSUM = 2*BW+4,
  parameter int COL     = 8,
  parameter int SETTLE  = 3,
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W:0]        num_rows,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   ofifo_valid,
  output logic                   ofifo_rd,
  input  logic [BW_PSUM*COL-1:0] ofifo_out,
  output logic [BW_PSUM*COL-1:0] norm_in,
  output logic                   norm_valid,
  input  logic                   norm_div_complete,
  input  logic [BW_PSUM*COL-1:0] norm_out,
  output logic                   mem_wen,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [BW_PSUM*COL-1:0] mem_din
);
  localparam int W  = BW_PSUM*COL;
  localparam int CW = $clog2(TIMEOUT+1);
  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_LOAD, S_ARM, S_WAIT_BUSY, S_WAIT_DONE, S_SETTLE, S_STORE, S_GAP, S_FIN
  } state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W:0]   r_num, r_rows;
  logic [ADDR_W-1:0] r_addr;
  logic [W-1:0]      r_norm_in, r_din;
  logic              r_busy, r_done, r_err, r_rd, r_nv, r_wen;
  logic              w_to;
  assign w_to = r_cnt == CW'(TIMEOUT-1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = !start ? S_IDLE : (num_rows == '0) ? S_FIN : S_POP;
      S_POP:       w_next = r_rd ? S_LOAD : S_POP;
      S_LOAD:      w_next = S_ARM;
      S_ARM:       w_next = (r_cnt == CW'(1)) ? S_WAIT_BUSY : S_ARM;
      S_WAIT_BUSY: w_next = !norm_div_complete ? S_WAIT_DONE : w_to ? S_FIN : S_WAIT_BUSY;
      S_WAIT_DONE: w_next = norm_div_complete ? S_SETTLE : w_to ? S_FIN : S_WAIT_DONE;
      S_SETTLE:    w_next = (r_cnt == CW'(SETTLE-1)) ? S_STORE : S_SETTLE;
      S_STORE:     w_next = (r_rows + (ADDR_W+1)'(1) == r_num) ? S_FIN : S_GAP;
      S_GAP:       w_next = S_POP;
      default:     w_next = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_num     <= '0;
      r_rows    <= '0;
      r_addr    <= '0;
      r_norm_in <= '0;
      r_din     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd      <= 1'b0;
      r_nv      <= 1'b0;
      r_wen     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      r_rd    <= (w_next == S_POP) && ofifo_valid;
      r_nv    <= w_next == S_ARM;
      r_wen   <= w_next == S_STORE;
      r_done  <= w_next == S_FIN;
      r_busy  <= (w_next != S_IDLE) && (w_next != S_FIN);
      if (r_state == S_LOAD) r_norm_in <= ofifo_out;
      if (w_next == S_STORE) r_din <= norm_out;
      if (r_state == S_IDLE && start) begin
        r_num  <= num_rows;
        r_rows <= '0;
        r_addr <= '0;
        r_err  <= 1'b0;
      end else if (r_state == S_STORE) begin
        r_rows <= r_rows + (ADDR_W+1)'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
      if ((r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) && w_next == S_FIN) r_err <= 1'b1;
    end
  end
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign ofifo_rd   = r_rd;
  assign norm_in    = r_norm_in;
  assign norm_valid = r_nv;
  assign mem_wen    = r_wen;
  assign mem_addr   = r_addr;
  assign mem_din    = r_din;
endmodule

// File: tb/tb_norm_feeder.sv
// tb_norm_feeder: random rows through a behavioural ofifo and normalizer, checked
// against a queue of expected (address, scaled row) writes built from the job description.
module tb_norm_feeder;
  localparam int W  = 160;
  localparam int AW = 4;
  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW:0]   num_rows;
  logic          busy, done, err, ofifo_rd, norm_valid, mem_wen;
  logic          ofifo_valid = 1'b0;
  logic          ndc = 1'b1;
  logic [W-1:0]  ofifo_out = '0, norm_out = '0;
  logic [W-1:0]  norm_in, mem_din;
  logic [AW-1:0] mem_addr;

  norm_feeder dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .err(err),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .ofifo_out(ofifo_out),
    .norm_in(norm_in), .norm_valid(norm_valid), .norm_div_complete(ndc), .norm_out(norm_out),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // the normalizer under test scales every lane by 16
  function automatic logic [W-1:0] scale(input logic [W-1:0] r);
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) o[i*20 +: 20] = 20'(r[i*20 +: 20] * 16);
    return o;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*20 +: 20] = 20'($urandom);
    return r;
  endfunction

  // ofifo: row appears on ofifo_out the cycle after the pop strobe
  logic [W-1:0] src_q[$];
  logic         starve = 1'b0;
  always @(posedge clk) begin
    if (ofifo_rd) begin
      if (src_q.size() == 0) chk("pop_empty", W'(1), W'(0));
      else begin
        ofifo_out <= src_q[0];
        src_q.pop_front();
      end
    end
    ofifo_valid <= (src_q.size() != 0) && !starve;
  end

  // normalizer: drops div_complete after a delay, raises it later, result valid 3 cycles after
  logic         hang = 1'b0, slow = 1'b0, nv_q = 1'b0;
  int           ph = 0, t = 0;
  logic [W-1:0] res = '0;
  always @(posedge clk) begin
    nv_q <= norm_valid;
    if (reset) begin
      ph  <= 0;
      ndc <= 1'b1;
    end else case (ph)
      0: if (norm_valid && !nv_q && !hang) begin
           res <= scale(norm_in);
           t   <= $urandom_range(0, 2);
           ph  <= 1;
         end
      1: if (t == 0) begin
           ndc <= 1'b0;
           t   <= slow ? 12 : $urandom_range(0, 3);
           ph  <= 2;
         end else t <= t - 1;
      2: if (t == 0) begin
           ndc      <= 1'b1;
           norm_out <= ~res;
           t        <= 2;
           ph       <= 3;
         end else t <= t - 1;
      default: if (t == 0) begin
           norm_out <= res;
           ph       <= 0;
         end else t <= t - 1;
    endcase
  end

  // reference: expected writes in order, plus per-cycle protocol checks
  int            exp_addr[$];
  logic [W-1:0]  exp_data[$];
  int            wcount = 0;
  bit            exp_wen_done = 1'b1;
  int            n_rd = 0, n_wen = 0, n_edges = 0, n_done = 0, nv_run = 0;
  logic          prev_wen = 1'b0;
  logic [W-1:0]  last_din = '0;
  logic [AW-1:0] last_addr = '0;
  always @(negedge clk) begin
    if (reset) begin
      nv_run   = 0;
      prev_wen = 1'b0;
    end else begin
      if (mem_wen) begin
        n_wen++;
        last_din  = mem_din;
        last_addr = mem_addr;
        if (exp_data.size() == 0) chk("unexpected_wen", W'(1), W'(0));
        else begin
          chk("wr_addr", W'(mem_addr), W'(exp_addr.pop_front()));
          chk("wr_data", mem_din, exp_data.pop_front());
        end
      end
      if (ofifo_rd) n_rd++;
      if (norm_valid) nv_run++;
      else if (nv_run != 0) begin
        chk("nv_width", W'(nv_run), W'(2));
        nv_run = 0;
        n_edges++;
      end
      if (done) begin
        n_done++;
        chk("done_after_wen", W'(prev_wen), W'(exp_wen_done));
        chk("busy_at_done", W'(busy), W'(0));
        chk("writes_left_at_done", W'(exp_data.size()), W'(0));
      end
      prev_wen = mem_wen;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [W-1:0] r, input bit wr);
    src_q.push_back(r);
    if (wr) begin
      exp_data.push_back(scale(r));
      exp_addr.push_back(wcount % 16);
      wcount++;
    end
  endtask

  task automatic start_job(input int n);
    num_rows = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 3000) begin
      tick();
      c++;
    end
    if (!done) chk("done_seen", W'(0), W'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
    chk({tag, "_err"}, W'(err), W'(0));
    chk({tag, "_rd"}, W'(ofifo_rd), W'(0));
    chk({tag, "_nv"}, W'(norm_valid), W'(0));
    chk({tag, "_norm_in"}, norm_in, W'(0));
    chk({tag, "_wen"}, W'(mem_wen), W'(0));
    chk({tag, "_addr"}, W'(mem_addr), W'(0));
    chk({tag, "_din"}, mem_din, W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c, s_rd, s_wen, s_edges, s_done;
    logic [W-1:0] row;
    reset = 1'b1; start = 1'b0; num_rows = '0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // single row with literal timeline and results
    row = '0;
    row[19:0] = 20'd4; row[39:20] = 20'hFFFFC; row[59:40] = 20'd8;
    wcount = 0; exp_wen_done = 1'b1;
    push_row(row, 1'b1);
    tick();
    start_job(1);
    chk("t1_busy_c1", W'(busy), W'(1));
    chk("t1_rd_c1", W'(ofifo_rd), W'(1));
    tick(); tick();
    chk("t1_nv_c3", W'(norm_valid), W'(1));
    chk("t1_norm_in_c3", norm_in, row);
    tick();
    chk("t1_nv_c4", W'(norm_valid), W'(1));
    tick();
    chk("t1_nv_c5", W'(norm_valid), W'(0));
    wait_done(c);
    chk("t1_err", W'(err), W'(0));
    chk("t1_addr", W'(last_addr), W'(0));
    chk("t1_lane0", W'(last_din[19:0]), W'(20'd64));
    chk("t1_lane1", W'(last_din[39:20]), W'(20'hFFFC0));
    chk("t1_lane2", W'(last_din[59:40]), W'(20'd128));
    chk("t1_lanes_hi", W'(last_din[159:60]), W'(0));
    tick();

    // eight back-to-back rows, with an ignored start mid-job
    s_rd = n_rd; s_wen = n_wen; s_edges = n_edges; wcount = 0;
    for (int i = 0; i < 8; i++) push_row(rand_row(), 1'b1);
    tick();
    start_job(8);
    repeat (10) tick();
    num_rows = 1; start = 1'b1; tick(); start = 1'b0;
    wait_done(c);
    chk("t2_rd", W'(n_rd - s_rd), W'(8));
    chk("t2_edges", W'(n_edges - s_edges), W'(8));
    chk("t2_wen", W'(n_wen - s_wen), W'(8));
    chk("t2_last_addr", W'(last_addr), W'(7));
    chk("t2_err", W'(err), W'(0));
    tick();

    // starvation: parks in POP well past the timeout, then finishes
    s_rd = n_rd; s_wen = n_wen; s_done = n_done; wcount = 0;
    push_row(rand_row(), 1'b1);
    tick();
    start_job(3);
    c = 0;
    while (n_rd - s_rd < 1 && c < 50) begin tick(); c++; end
    starve = 1'b1;
    push_row(rand_row(), 1'b1);
    push_row(rand_row(), 1'b1);
    c = 0;
    while (n_wen - s_wen < 1 && c < 200) begin tick(); c++; end
    chk("t3_first_write", W'(n_wen - s_wen), W'(1));
    repeat (80) tick();
    chk("t3_rd_parked", W'(n_rd - s_rd), W'(1));
    chk("t3_busy_parked", W'(busy), W'(1));
    chk("t3_err_parked", W'(err), W'(0));
    chk("t3_no_done", W'(n_done - s_done), W'(0));
    starve = 1'b0;
    wait_done(c);
    chk("t3_rd", W'(n_rd - s_rd), W'(3));
    chk("t3_wen", W'(n_wen - s_wen), W'(3));
    chk("t3_err", W'(err), W'(0));
    tick();

    // hung normalizer: watchdog fires after 64 cycles in WAIT_BUSY
    hang = 1'b1; exp_wen_done = 1'b0; s_wen = n_wen;
    push_row(rand_row(), 1'b0);
    tick();
    start_job(1);
    wait_done(c);
    chk("t4_done_cycle", W'(c), W'(69));
    chk("t4_err", W'(err), W'(1));
    chk("t4_nv", W'(norm_valid), W'(0));
    chk("t4_wen", W'(n_wen - s_wen), W'(0));
    tick();
    chk("t4_err_sticky", W'(err), W'(1));
    hang = 1'b0;
    tick();

    // wrap: 17 rows, the last lands at address 0
    exp_wen_done = 1'b1; s_wen = n_wen; wcount = 0;
    for (int i = 0; i < 17; i++) push_row(rand_row(), 1'b1);
    tick();
    start_job(17);
    chk("t5_err_cleared", W'(err), W'(0));
    wait_done(c);
    chk("t5_wen", W'(n_wen - s_wen), W'(17));
    chk("t5_last_addr", W'(last_addr), W'(0));
    tick();

    // zero length: done on the cycle after start, nothing popped or written
    exp_wen_done = 1'b0; s_rd = n_rd; s_wen = n_wen;
    start_job(0);
    chk("t5z_done", W'(done), W'(1));
    tick();
    chk("t5z_rd", W'(n_rd - s_rd), W'(0));
    chk("t5z_wen", W'(n_wen - s_wen), W'(0));
    tick();

    // reset mid WAIT_DONE, then a clean job
    slow = 1'b1; exp_wen_done = 1'b1; wcount = 0;
    push_row(rand_row(), 1'b1);
    tick();
    start_job(1);
    c = 0;
    while (ndc && c < 50) begin tick(); c++; end
    chk("t6_div_started", W'(ndc), W'(0));
    repeat (3) tick();
    reset = 1'b1;
    exp_data.delete(); exp_addr.delete();
    s_done = n_done;
    tick();
    chk_reset_outputs("t6");
    reset = 1'b0;
    slow = 1'b0;
    repeat (30) tick();
    chk("t6_no_done", W'(n_done - s_done), W'(0));
    s_wen = n_wen; wcount = 0;
    push_row(rand_row(), 1'b1);
    push_row(rand_row(), 1'b1);
    tick();
    start_job(2);
    wait_done(c);
    chk("t6_wen", W'(n_wen - s_wen), W'(2));
    chk("t6_err", W'(err), W'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
